// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver: one digit per slot, shadowed inputs per frame,
// hex/BCD decode, leading-zero suppression, blank/blink, and anode dead time.
module seg7_scan_driver #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned DEAD_CYC     = 0,
    parameter int unsigned BLINK_FRAMES = 32,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4*NUM_DIGITS-1:0]   digits_i,
    input  logic [NUM_DIGITS-1:0]     dp_i,
    input  logic [NUM_DIGITS-1:0]     blank_i,
    input  logic [NUM_DIGITS-1:0]     blink_i,
    input  logic                      hex_en,
    input  logic                      lz_en,
    output logic [6:0]                seg_o,
    output logic                      dp_o,
    output logic [NUM_DIGITS-1:0]     an_o,
    output logic                      frame_o
);

    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int unsigned DW = 4 * NUM_DIGITS;

    logic [CW-1:0]         r_cnt;
    logic [IW-1:0]         r_idx;
    logic [FW-1:0]         r_fcnt;
    logic                  r_phase;
    logic [DW-1:0]         r_dig_s;
    logic [NUM_DIGITS-1:0] r_dp_s;
    logic [NUM_DIGITS-1:0] r_blank_s;
    logic [NUM_DIGITS-1:0] r_blink_s;
    logic                  r_frame_pend;

    logic [6:0]            r_seg;
    logic                  r_dp;
    logic [NUM_DIGITS-1:0] r_an;
    logic                  r_frame;

    logic                  w_slot_end;
    logic                  w_wrap;
    logic                  w_dead;
    logic [3:0]            w_code;
    logic                  w_dp_sel;
    logic                  w_dark;
    logic                  w_lz;
    logic                  w_zero_run;
    logic [NUM_DIGITS-1:0] w_an_oh;
    logic [6:0]            w_seg_n;
    logic                  w_dp_n;
    logic [NUM_DIGITS-1:0] w_an_n;

    // Active-high segment pattern for a code; BCD mode maps 10..15 to "E".
    function automatic logic [6:0] f_decode(input logic [3:0] code, input logic hex);
        logic [6:0] pat;
        case (code)
            4'h0: pat = 7'h3F;
            4'h1: pat = 7'h06;
            4'h2: pat = 7'h5B;
            4'h3: pat = 7'h4F;
            4'h4: pat = 7'h66;
            4'h5: pat = 7'h6D;
            4'h6: pat = 7'h7D;
            4'h7: pat = 7'h07;
            4'h8: pat = 7'h7F;
            4'h9: pat = 7'h6F;
            4'hA: pat = 7'h77;
            4'hB: pat = 7'h7C;
            4'hC: pat = 7'h39;
            4'hD: pat = 7'h5E;
            4'hE: pat = 7'h79;
            default: pat = 7'h71;
        endcase
        if (!hex && (code > 4'd9)) begin
            pat = 7'h79;
        end
        return pat;
    endfunction

    assign w_slot_end = (r_cnt == CW'(SCAN_DIV - 1));
    assign w_wrap     = w_slot_end && (r_idx == IW'(NUM_DIGITS - 1));

    generate
        if (DEAD_CYC == 0) begin : g_no_dead
            assign w_dead = 1'b0;
        end else begin : g_dead
            assign w_dead = (r_cnt < CW'(DEAD_CYC));
        end
    endgenerate

    // Slot prescaler and digit index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            r_idx <= w_wrap ? '0 : r_idx + IW'(1);
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Frame-start capture of inputs, blink frame counter and phase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dig_s      <= '0;
            r_dp_s       <= '0;
            r_blank_s    <= '0;
            r_blink_s    <= '0;
            r_fcnt       <= '0;
            r_phase      <= 1'b0;
            r_frame_pend <= 1'b0;
        end else begin
            r_frame_pend <= w_wrap;
            if (w_wrap) begin
                r_dig_s   <= digits_i;
                r_dp_s    <= dp_i;
                r_blank_s <= blank_i;
                r_blink_s <= blink_i;
                if (r_fcnt == FW'(BLINK_FRAMES - 1)) begin
                    r_fcnt  <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_fcnt <= r_fcnt + FW'(1);
                end
            end
        end
    end

    // Select the current digit; scan from the top to track the all-zero run above it.
    always_comb begin
        w_code     = '0;
        w_dp_sel   = 1'b0;
        w_dark     = 1'b0;
        w_lz       = 1'b0;
        w_zero_run = 1'b1;
        w_an_oh    = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_zero_run = w_zero_run && (r_dig_s[4*k +: 4] == 4'd0);
            if (IW'(k) == r_idx) begin
                w_code     = r_dig_s[4*k +: 4];
                w_dp_sel   = r_dp_s[k];
                w_dark     = r_blank_s[k] || (r_blink_s[k] && r_phase);
                w_lz       = lz_en && (k != 0) && w_zero_run;
                w_an_oh[k] = 1'b1;
            end
        end
    end

    always_comb begin
        w_seg_n = (w_dark || w_lz) ? 7'h00 : f_decode(w_code, hex_en);
        w_dp_n  = w_dark ? 1'b0 : w_dp_sel;
        w_an_n  = (w_dark || w_dead) ? '0 : w_an_oh;
    end

    // Output registers; polarity applied here so reset gives the inactive level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seg   <= {7{ACTIVE_LOW}};
            r_dp    <= ACTIVE_LOW;
            r_an    <= {NUM_DIGITS{ACTIVE_LOW}};
            r_frame <= 1'b0;
        end else begin
            r_seg   <= w_seg_n ^ {7{ACTIVE_LOW}};
            r_dp    <= w_dp_n ^ ACTIVE_LOW;
            r_an    <= w_an_n ^ {NUM_DIGITS{ACTIVE_LOW}};
            r_frame <= r_frame_pend;
        end
    end

    assign seg_o   = r_seg;
    assign dp_o    = r_dp;
    assign an_o    = r_an;
    assign frame_o = r_frame;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with 4 digits, 4-cycle slots, 1 dead cycle, 2-frame blink.
module tb_seg7_scan_driver;

    logic        clk;
    logic        rst_n;
    logic [15:0] digits_i;
    logic [3:0]  dp_i;
    logic [3:0]  blank_i;
    logic [3:0]  blink_i;
    logic        hex_en;
    logic        lz_en;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic [3:0]  an_o;
    logic        frame_o;

    int n_tests;
    int n_fail;

    seg7_scan_driver #(
        .NUM_DIGITS  (4),
        .SCAN_DIV    (4),
        .DEAD_CYC    (1),
        .BLINK_FRAMES(2),
        .ACTIVE_LOW  (1'b1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .digits_i(digits_i),
        .dp_i    (dp_i),
        .blank_i (blank_i),
        .blink_i (blink_i),
        .hex_en  (hex_en),
        .lz_en   (lz_en),
        .seg_o   (seg_o),
        .dp_o    (dp_o),
        .an_o    (an_o),
        .frame_o (frame_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // After this, the next step shows digit 0, first (dead) cycle of frame 0.
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [3:0] exp_an;
        rst_n = 1'b0;
        digits_i = 16'h0000; dp_i = '0; blank_i = '0; blink_i = '0;
        hex_en = 1'b0; lz_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (an_o !== 4'hF || seg_o !== 7'h7F || dp_o !== 1'b1 || frame_o !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold cyc%0d got an=%h seg=%h dp=%b fr=%b exp an=F seg=7F dp=1 fr=0",
                         i, an_o, seg_o, dp_o, frame_o);
            end
        end
        rst_n = 1'b1;
        for (int f = 0; f < 2; f++) begin
            for (int d = 0; d < 4; d++) begin
                for (int c = 0; c < 4; c++) begin
                    step();
                    exp_an = (c == 0) ? 4'hF : 4'(~(4'b0001 << d));
                    n_tests++;
                    if (an_o !== exp_an || seg_o !== 7'h40) begin
                        n_fail++;
                        $display("FAIL scan f%0d d%0d c%0d got an=%h seg=%h exp an=%h seg=40",
                                 f, d, c, an_o, seg_o, exp_an);
                    end
                    if (f > 0 || d > 0 || c > 0) begin
                        n_tests++;
                        if (frame_o !== (f == 1 && d == 0 && c == 0)) begin
                            n_fail++;
                            $display("FAIL scan_frame f%0d d%0d c%0d got %b exp %b",
                                     f, d, c, frame_o, (f == 1 && d == 0 && c == 0));
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_bcd_hex();
        logic [6:0] exp_seg [4];
        digits_i = 16'hA921; hex_en = 1'b0; lz_en = 1'b0;
        dp_i = '0; blank_i = '0; blink_i = '0;
        do_reset();
        repeat (16) step();
        exp_seg[0] = 7'h79; exp_seg[1] = 7'h24; exp_seg[2] = 7'h10; exp_seg[3] = 7'h06;
        for (int f = 0; f < 2; f++) begin
            if (f == 1) begin
                hex_en = 1'b1;
                exp_seg[3] = 7'h08;
            end
            for (int d = 0; d < 4; d++) begin
                for (int c = 0; c < 4; c++) begin
                    step();
                    n_tests++;
                    if (seg_o !== exp_seg[d] || dp_o !== 1'b1) begin
                        n_fail++;
                        $display("FAIL bcd_hex hex%0d d%0d c%0d got seg=%h dp=%b exp seg=%h dp=1",
                                 f, d, c, seg_o, dp_o, exp_seg[d]);
                    end
                end
            end
        end
    endtask

    task automatic test_lz();
        logic [6:0] exp_seg [4];
        logic [3:0] exp_an;
        digits_i = 16'h0050; lz_en = 1'b1; hex_en = 1'b0;
        dp_i = '0; blank_i = '0; blink_i = '0;
        do_reset();
        repeat (16) step();
        exp_seg[0] = 7'h40; exp_seg[1] = 7'h12; exp_seg[2] = 7'h7F; exp_seg[3] = 7'h7F;
        for (int f = 0; f < 2; f++) begin
            for (int d = 0; d < 4; d++) begin
                for (int c = 0; c < 4; c++) begin
                    step();
                    if (f == 0 && d == 2 && c == 0) digits_i = 16'h0000;
                    exp_an = (c == 0) ? 4'hF : 4'(~(4'b0001 << d));
                    n_tests++;
                    if (seg_o !== exp_seg[d] || an_o !== exp_an) begin
                        n_fail++;
                        $display("FAIL lz f%0d d%0d c%0d got seg=%h an=%h exp seg=%h an=%h",
                                 f, d, c, seg_o, an_o, exp_seg[d], exp_an);
                    end
                end
            end
            exp_seg[1] = 7'h7F;
        end
    endtask

    task automatic test_frame_coherence();
        logic [6:0] old_seg [4];
        logic [6:0] new_seg [4];
        logic [6:0] exp_seg;
        digits_i = 16'h1234; lz_en = 1'b0; hex_en = 1'b0;
        dp_i = '0; blank_i = '0; blink_i = '0;
        old_seg[0] = 7'h19; old_seg[1] = 7'h30; old_seg[2] = 7'h24; old_seg[3] = 7'h79;
        new_seg[0] = 7'h00; new_seg[1] = 7'h78; new_seg[2] = 7'h02; new_seg[3] = 7'h12;
        do_reset();
        repeat (16) step();
        for (int f = 0; f < 2; f++) begin
            for (int d = 0; d < 4; d++) begin
                for (int c = 0; c < 4; c++) begin
                    step();
                    if (f == 0 && d == 2 && c == 0) digits_i = 16'h5678;
                    exp_seg = (f == 0) ? old_seg[d] : new_seg[d];
                    n_tests++;
                    if (seg_o !== exp_seg) begin
                        n_fail++;
                        $display("FAIL coherence f%0d d%0d c%0d got seg=%h exp %h",
                                 f, d, c, seg_o, exp_seg);
                    end
                    n_tests++;
                    if (frame_o !== (d == 0 && c == 0)) begin
                        n_fail++;
                        $display("FAIL coherence_frame f%0d d%0d c%0d got %b exp %b",
                                 f, d, c, frame_o, (d == 0 && c == 0));
                    end
                end
            end
        end
    endtask

    task automatic test_blink_blank();
        logic [6:0] exp_seg;
        logic       exp_dp;
        logic [3:0] exp_an;
        logic       dark0;
        digits_i = 16'h0000; lz_en = 1'b0; hex_en = 1'b0;
        blink_i = 4'b0001; dp_i = 4'b0010; blank_i = 4'b1000;
        do_reset();
        repeat (16) step();
        // Frames 1..5: blink phase is 0,1,1,0,0.
        for (int f = 1; f <= 5; f++) begin
            dark0 = (f == 2 || f == 3);
            for (int d = 0; d < 4; d++) begin
                for (int c = 0; c < 4; c++) begin
                    step();
                    exp_seg = 7'h40;
                    exp_dp  = 1'b1;
                    exp_an  = (c == 0) ? 4'hF : 4'(~(4'b0001 << d));
                    if (d == 3 || (d == 0 && dark0)) begin
                        exp_seg = 7'h7F;
                        exp_an  = 4'hF;
                    end
                    if (d == 1) exp_dp = 1'b0;
                    n_tests++;
                    if (seg_o !== exp_seg || dp_o !== exp_dp || an_o !== exp_an) begin
                        n_fail++;
                        $display("FAIL blink_blank f%0d d%0d c%0d got seg=%h dp=%b an=%h exp seg=%h dp=%b an=%h",
                                 f, d, c, seg_o, dp_o, an_o, exp_seg, exp_dp, exp_an);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp_an;
        digits_i = 16'h1234; lz_en = 1'b0; hex_en = 1'b0;
        dp_i = 4'b1111; blank_i = '0; blink_i = '0;
        do_reset();
        repeat (16) step();
        // Showing digit 2 cycle 1, so the state is idx=2, cnt=2.
        repeat (10) step();
        n_tests++;
        if (seg_o !== 7'h24 || dp_o !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_pre got seg=%h dp=%b exp seg=24 dp=0", seg_o, dp_o);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_tests++;
        if (an_o !== 4'hF || seg_o !== 7'h7F || dp_o !== 1'b1 || frame_o !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset got an=%h seg=%h dp=%b fr=%b exp an=F seg=7F dp=1 fr=0",
                     an_o, seg_o, dp_o, frame_o);
        end
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
                step();
                exp_an = (c == 0) ? 4'hF : 4'(~(4'b0001 << d));
                n_tests++;
                if (an_o !== exp_an || seg_o !== 7'h40 || dp_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL mid_restart d%0d c%0d got an=%h seg=%h dp=%b exp an=%h seg=40 dp=1",
                             d, c, an_o, seg_o, dp_o, exp_an);
                end
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        digits_i = '0; dp_i = '0; blank_i = '0; blink_i = '0;
        hex_en = 1'b0; lz_en = 1'b0;
        test_reset();
        test_bcd_hex();
        test_lz();
        test_frame_coherence();
        test_blink_blank();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, time-multiplexed seven-segment display driver for the digital clock's display path. Takes NUM_DIGITS packed 4-bit digit codes and drives one shared segment bus plus per-digit enables, scanning one digit per slot. Adds what a plain per-digit decoder lacks:
- hex/BCD mode
- leading-zero suppression
- per-digit blanking and blinking
- anti-ghosting dead time
- frame-coherent input capture

## Interface
- NUM_DIGITS, 4: digits scanned, ≥2.
- SCAN_DIV, 50000: clock cycles per digit slot, ≥2.
- DEAD_CYC, 0: cycles at the start of each slot with all enables off, 0..SCAN_DIV-1.
- BLINK_FRAMES, 32: frames per blink half-period, ≥1.
- ACTIVE_LOW, 1: 1 means seg_o, dp_o and an_o are active-low; 0 means active-high.

- clk  in  1  system clock; single clock domain.
- rst_n  in  1  reset; synchronous, active-low.
- digits_i  in  4*NUM_DIGITS  digit codes; digit k is bits [4k+3:4k]; digit 0 is rightmost/least significant.
- dp_i  in  NUM_DIGITS  decimal point request per digit.
- blank_i  in  NUM_DIGITS  force digit k dark, including its dp.
- blink_i  in  NUM_DIGITS  digit k is blanked during blink phase 1.
- hex_en  in  1  1: codes A–F are shown as letters; 0: BCD, codes ≥10 are shown as "E".
- lz_en  in  1  leading-zero suppression enable.
- seg_o  out  7  segments {g,f,e,d,c,b,a}.
- dp_o  out  1  decimal point.
- an_o  out  NUM_DIGITS  digit enables, one-hot or all-off.
- frame_o  out  1  one-cycle pulse at each frame start.

## Operation
- **Segment patterns** are given active-high as {g..a} hex values. ACTIVE_LOW inverts all of seg_o, dp_o and an_o.
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
  - blank: 00.
- **State:**
  - prescaler cnt, 0..SCAN_DIV-1
  - digit index idx, 0..NUM_DIGITS-1
  - shadow registers for digits_i, dp_i, blank_i and blink_i
  - frame counter, 0..BLINK_FRAMES-1
  - blink phase bit
- **Slot advance:** cnt increments every cycle. At cnt==SCAN_DIV-1, cnt goes to 0 and idx increments, wrapping from NUM_DIGITS-1 to 0.
- **Frame start** is the edge where idx wraps to 0. On that edge:
  - the shadow registers load from the inputs;
  - frame_o pulses;
  - the frame counter advances. On its wrap, the blink phase toggles.
- Inputs are only sampled at frame start, so mid-frame input changes never tear a frame.
- **Display rules for the digit selected by idx, in priority order:**
  1. blank_s[idx], or (blink_s[idx] and phase==1): segments and dp off, anode off.
  2. Leading-zero suppression: lz_en=1, idx≠0, and shadow digits idx..NUM_DIGITS-1 are all 0. Segments off, dp per dp_s, anode on. lz_en is sampled live, not shadowed.
  3. Otherwise: pattern of the code under the live hex_en, dp per dp_s, anode on.
- **Dead time:** while cnt<DEAD_CYC, an_o is all-off. seg_o and dp_o still follow the rules above.
- Digit 0 is never leading-zero suppressed.

## Timing
- All outputs are registered and lag the (cnt, idx, shadow, phase) state by exactly one clock.
- Each digit's anode is on for SCAN_DIV-DEAD_CYC consecutive cycles per slot.
- Frame period is NUM_DIGITS*SCAN_DIV cycles.
- frame_o is high in the cycle after the wrap edge, concurrent with the first output cycle of digit 0.
- **Reset** (rst_n low at an edge), taking effect that edge:
  - cnt=0, idx=0, shadow=0, frame counter=0, phase=0.
  - seg_o, dp_o and an_o all inactive: 7F/1/all-ones for ACTIVE_LOW=1; 00/0/all-zeros for ACTIVE_LOW=0.
  - frame_o=0.
- Reset mid-slot or mid-frame discards the slot with no residual output.
- The first frame after reset displays the reset shadow, all-zero codes. The new inputs appear from the second frame.
- Simultaneous events are resolved at a single edge:
  - the last slot of a frame wraps;
  - the shadow loads;
  - the blink toggle fires.

## Test plan
Common parameters: NUM_DIGITS=4, SCAN_DIV=4, DEAD_CYC=1, BLINK_FRAMES=2, ACTIVE_LOW=1.

- **Reset and scan:** hold rst_n=0 for 3 cycles, then release.
  - During reset: an_o=F, seg_o=7F, frame_o=0.
  - After release: an_o sequence per slot is F,E,E,E then F,D,D,D then F,B,B,B then F,7,7,7. frame_o pulses every 16 cycles.
- **BCD vs hex:** digits_i=16'hA921.
  - hex_en=0: digit0 seg_o=~06=79, digit1 ~5B=24, digit2 ~6F=10, digit3 ~79=06.
  - hex_en=1: digit3 becomes ~77=08.
- **Leading-zero suppression:** digits_i=16'h0050, lz_en=1.
  - Digits 3 and 2 show seg_o=7F with anodes still pulsed.
  - Digits 1 and 0 show 12 and 40.
  - digits_i=16'h0000: only digit0 shows 40.
- **Frame coherence:** change digits_i from 1234 to 5678 during idx=2.
  - The rest of that frame shows 1234.
  - The next frame shows 5678.
  - frame_o aligns with the first digit0 output cycle.
- **Blink and blank:** blink_i=4'b0001, dp_i=4'b0010, blank_i=4'b1000.
  - Digit0 is dark during alternate 2-frame windows.
  - Digit1 dp_o=0 every frame.
  - Digit3 anode is never asserted.
- **Reset mid-frame:** pulse rst_n low at idx=2, cnt=2.
  - Next cycle: all outputs are at reset values.
  - Scanning restarts from digit0 with DEAD_CYC behaviour intact.
